// File: rtl/exec_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : exec_trace_pkg                                                    |
// | Purpose: Shared types and constants for the execution-trace monitor.       |
// |          trace_state_t - capture state machine encoding                    |
// |          trace_entry_t - one trace RAM word {pc, instr}                    |
// |          HIT_W         - width of each watch-hit counter                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package exec_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

  localparam int HIT_W = 16;

endpackage
`default_nettype wire

// File: rtl/exec_trace_monitor_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : trace_ram                                                         |
// | Purpose: Simple dual-port DEPTH x 64 trace store. One write port, one      |
// |          registered read port (1-cycle latency). Written so that FPGA      |
// |          tools infer block RAM: no reset on the array or read register.    |
// | Ports  : i_clk            clock                                           |
// |          i_we/i_waddr/i_wdata   write port                                 |
// |          i_re/i_raddr           read request                               |
// |          o_rdata                read data, valid the cycle after i_re      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module trace_ram
  import exec_trace_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  trace_entry_t             i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output trace_entry_t             o_rdata
);

  trace_entry_t mem_q [DEPTH];
  trace_entry_t rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/exec_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : exec_trace_monitor                                                |
// | Purpose: Execution-trace and watchpoint monitor for the retire stream and  |
// |          data bus. Captures {PC, instr} into a circular trace RAM around a |
// |          PC or watch-range trigger, counts per-channel watch hits and      |
// |          offers a frozen-trace readback port.                              |
// | Ports  : i_clk, i_reset_n (sync, active-low)                               |
// |          i_retire/i_PC/i_instruction      retire stream                   |
// |          i_mem_DV/i_mem_write/i_mem_address data bus tap                   |
// |          i_arm, i_trig_pc, i_trig_pc_en, i_trig_watch_mask, i_post_count  |
// |          i_watch_lo/i_watch_hi  inclusive range per watch channel          |
// |          i_rd_en/i_rd_idx -> o_rd_valid/o_rd_pc/o_rd_instr (1-cycle)      |
// |          o_state, o_fill, o_instr_count, o_watch_hits, o_stall             |
// | Config : EXEC_TRACE_STALL_DETECT_EN - build the retire-stall detector;     |
// |          when undefined o_stall is tied to 0.                              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module exec_trace_monitor
  import exec_trace_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int NUM_WATCH   = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_retire,
  input  logic [31:0]                i_PC,
  input  logic [31:0]                i_instruction,
  input  logic                       i_mem_DV,
  input  logic                       i_mem_write,
  input  logic [31:0]                i_mem_address,
  input  logic                       i_arm,
  input  logic [31:0]                i_trig_pc,
  input  logic                       i_trig_pc_en,
  input  logic [NUM_WATCH-1:0]       i_trig_watch_mask,
  input  logic [15:0]                i_post_count,
  input  logic [32*NUM_WATCH-1:0]    i_watch_lo,
  input  logic [32*NUM_WATCH-1:0]    i_watch_hi,
  input  logic                       i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic                       o_rd_valid,
  output logic [31:0]                o_rd_pc,
  output logic [31:0]                o_rd_instr,
  output logic [1:0]                 o_state,
  output logic [$clog2(DEPTH):0]     o_fill,
  output logic [31:0]                o_instr_count,
  output logic [HIT_W*NUM_WATCH-1:0] o_watch_hits,
  output logic                       o_stall
);

  localparam int AW = $clog2(DEPTH);

  trace_state_t   state_q, state_d;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    fill_q, fill_d;
  logic [15:0]    post_q, post_d;
  logic [31:0]    instr_count_q;
  logic           rd_valid_q;
  logic [NUM_WATCH-1:0] watch_hit;
  logic           capture, trigger, rd_ok;
  logic [AW-1:0]  rd_addr;
  trace_entry_t   rd_data;

  // Read and write direction are irrelevant to hit counting.
  logic unused_mem_write;
  assign unused_mem_write = i_mem_write;

  // ---------------------------------------------------------------- watch
  for (genvar k = 0; k < NUM_WATCH; k++) begin : g_watch
    logic [HIT_W-1:0] hits_q;
    // lo > hi yields an empty range, so no special case is needed.
    assign watch_hit[k] = i_mem_DV &&
                          (i_mem_address >= i_watch_lo[32*k +: 32]) &&
                          (i_mem_address <= i_watch_hi[32*k +: 32]);
    always_ff @(posedge i_clk) begin
      if (!i_reset_n)                          hits_q <= '0;
      else if (watch_hit[k] && (hits_q != '1)) hits_q <= hits_q + 1'b1;
    end
    assign o_watch_hits[HIT_W*k +: HIT_W] = hits_q;
  end

  // ------------------------------------------------------------- capture FSM
  // An arm pulse restarts the capture, so the retire in that cycle is dropped
  // to leave fill at exactly 0.
  assign capture = i_retire && !i_arm &&
                   ((state_q == ST_ARMED) || (state_q == ST_POST));
  assign trigger = (state_q == ST_ARMED) &&
                   ((i_retire && i_trig_pc_en && (i_PC == i_trig_pc)) ||
                    (|(watch_hit & i_trig_watch_mask)));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      post_q  <= post_d;
    end
  end

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    fill_d  = fill_q;
    if (i_arm) begin
      state_d = ST_ARMED;
      fill_d  = '0;
    end else begin
      if (capture && (fill_q != (AW+1)'(DEPTH))) fill_d = fill_q + 1'b1;
      case (state_q)
        ST_ARMED: begin
          if (trigger) begin
            if (i_post_count == 16'd0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
              post_d  = i_post_count;
            end
          end
        end
        ST_POST: begin
          // post_q is never 0 here: it is loaded only with a non-zero value.
          if (capture) begin
            post_d = post_q - 16'd1;
            if (post_q == 16'd1) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   wr_ptr_q <= '0;
    else if (capture) wr_ptr_q <= wr_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)    instr_count_q <= '0;
    else if (i_retire) instr_count_q <= instr_count_q + 32'd1;
  end

  // ---------------------------------------------------------------- readback
  // Index 0 is the oldest valid entry; a full buffer (fill == DEPTH) wraps to
  // wr_ptr itself because the truncated fill is 0.
  assign rd_addr = wr_ptr_q - fill_q[AW-1:0] + i_rd_idx;
  assign rd_ok   = i_rd_en &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                   ({1'b0, i_rd_idx} < fill_q);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) rd_valid_q <= 1'b0;
    else            rd_valid_q <= rd_ok;
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (capture),
    .i_waddr (wr_ptr_q),
    .i_wdata ('{pc: i_PC, instr: i_instruction}),
    .i_re    (rd_ok),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  // The RAM read register has no reset; gating by valid gives zero data
  // out of reset and between reads.
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_pc       = rd_valid_q ? rd_data.pc    : 32'd0;
  assign o_rd_instr    = rd_valid_q ? rd_data.instr : 32'd0;
  assign o_state       = state_q;
  assign o_fill        = fill_q;
  assign o_instr_count = instr_count_q;

  // ------------------------------------------------------------- stall detect
`ifdef EXEC_TRACE_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_retire)                stall_cnt_q <= '0;
    else if (stall_cnt_q != SW'(STALL_LIMIT))  stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign o_stall = (stall_cnt_q == SW'(STALL_LIMIT));
`else
  logic unused_stall_limit;
  assign unused_stall_limit = (STALL_LIMIT == 0);
  assign o_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exec_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_exec_trace_monitor                                             |
// | Purpose: Self-checking bench for exec_trace_monitor (DEPTH=16,             |
// |          NUM_WATCH=2, STALL_LIMIT=8). Table-driven watch/trigger vectors   |
// |          plus directed sequences for capture, wrap, reset and stall.       |
// |          Stall expectations follow EXEC_TRACE_STALL_DETECT_EN.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_exec_trace_monitor;

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_retire, i_mem_DV, i_mem_write, i_arm, i_trig_pc_en, i_rd_en;
  logic [31:0] i_PC, i_instruction, i_mem_address, i_trig_pc;
  logic [1:0]  i_trig_watch_mask;
  logic [15:0] i_post_count;
  logic [63:0] i_watch_lo, i_watch_hi;
  logic [3:0]  i_rd_idx;
  logic        o_rd_valid, o_stall;
  logic [31:0] o_rd_pc, o_rd_instr, o_instr_count;
  logic [1:0]  o_state;
  logic [4:0]  o_fill;
  logic [31:0] o_watch_hits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  exec_trace_monitor #(.DEPTH(16), .NUM_WATCH(2), .STALL_LIMIT(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_retire(i_retire), .i_PC(i_PC),
    .i_instruction(i_instruction), .i_mem_DV(i_mem_DV), .i_mem_write(i_mem_write),
    .i_mem_address(i_mem_address), .i_arm(i_arm), .i_trig_pc(i_trig_pc),
    .i_trig_pc_en(i_trig_pc_en), .i_trig_watch_mask(i_trig_watch_mask),
    .i_post_count(i_post_count), .i_watch_lo(i_watch_lo), .i_watch_hi(i_watch_hi),
    .i_rd_en(i_rd_en), .i_rd_idx(i_rd_idx), .o_rd_valid(o_rd_valid),
    .o_rd_pc(o_rd_pc), .o_rd_instr(o_rd_instr), .o_state(o_state), .o_fill(o_fill),
    .o_instr_count(o_instr_count), .o_watch_hits(o_watch_hits), .o_stall(o_stall)
  );

  typedef struct {
    logic        arm, retire, dv;
    logic [31:0] addr;
    logic [1:0]  mask;
    logic [15:0] post;
    logic [1:0]  st;
    logic [4:0]  fill;
    logic [15:0] h0, h1;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic exp_stall_hi;

  initial begin
`ifdef EXEC_TRACE_STALL_DETECT_EN
    exp_stall_hi = 1'b1;
`else
    exp_stall_hi = 1'b0;
`endif
    // Watch/trigger vectors: arm retire dv addr mask post | state fill hit0 hit1
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h1000_0000, 2'b00, 16'd0, 2'd3, 5'd8, 16'd1, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h1000_0007, 2'b00, 16'd0, 2'd3, 5'd8, 16'd2, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h1000_0008, 2'b00, 16'd0, 2'd3, 5'd8, 16'd2, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0018, 2'b00, 16'd0, 2'd3, 5'd8, 16'd2, 16'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 16'd0, 2'd1, 5'd0, 16'd2, 16'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h1000_0003, 2'b01, 16'd2, 2'd1, 5'd0, 16'd3, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h1000_0004, 2'b01, 16'd2, 2'd2, 5'd0, 16'd4, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'b01, 16'd2, 2'd2, 5'd1, 16'd4, 16'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'b01, 16'd2, 2'd3, 5'd2, 16'd4, 16'd0};

    i_reset_n = 1'b0; i_retire = 1'b0; i_PC = '0; i_instruction = '0;
    i_mem_DV = 1'b0; i_mem_write = 1'b0; i_mem_address = '0; i_arm = 1'b0;
    i_trig_pc = '0; i_trig_pc_en = 1'b0; i_trig_watch_mask = '0; i_post_count = '0;
    // Channel 0: 0x10000000..0x10000007; channel 1: lo > hi, never hits.
    i_watch_lo = {32'h0000_0020, 32'h1000_0000};
    i_watch_hi = {32'h0000_0010, 32'h1000_0007};
    i_rd_en = 1'b0; i_rd_idx = '0;

    // ---- reset state
    tick(); tick();
    i_reset_n = 1'b1;
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_fill", 64'(o_fill), 64'd0);
    check("rst_icount", 64'(o_instr_count), 64'd0);
    check("rst_hits", 64'(o_watch_hits), 64'd0);
    check("rst_rdvalid", 64'(o_rd_valid), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);

    // ---- PC trigger with post_count 3
    i_trig_pc = 32'h8000_0010; i_trig_pc_en = 1'b1; i_post_count = 16'd3;
    i_arm = 1'b1; tick(); i_arm = 1'b0;
    check("arm_state", 64'(o_state), 64'd1);
    for (int k = 0; k < 9; k++) begin
      i_retire = 1'b1;
      i_PC = 32'h8000_0000 + 32'(4 * k);
      i_instruction = i_PC ^ 32'hFFFF_0000;
      tick();
    end
    i_retire = 1'b0; i_trig_pc_en = 1'b0;
    check("t1_state", 64'(o_state), 64'd3);
    check("t1_fill", 64'(o_fill), 64'd8);
    check("t1_icount", 64'(o_instr_count), 64'd9);
    // Back-to-back readback of all 8 entries.
    for (int k = 0; k < 8; k++) begin
      i_rd_en = 1'b1; i_rd_idx = 4'(k);
      tick();
      check("t1_rd_valid", 64'(o_rd_valid), 64'd1);
      check("t1_rd_pc", 64'(o_rd_pc), 64'(32'h8000_0000 + 32'(4 * k)));
      check("t1_rd_instr", 64'(o_rd_instr), 64'((32'h8000_0000 + 32'(4 * k)) ^ 32'hFFFF_0000));
    end
    i_rd_idx = 4'd8; tick();
    check("rd_oob_valid", 64'(o_rd_valid), 64'd0);
    i_rd_en = 1'b0;

    // ---- table: watch counting and watch trigger
    for (int r = 0; r < 9; r++) begin
      i_arm = tbl[r].arm; i_retire = tbl[r].retire; i_PC = 32'h9000_0000 + 32'(r);
      i_mem_DV = tbl[r].dv; i_mem_address = tbl[r].addr;
      i_mem_write = r[0];
      i_trig_watch_mask = tbl[r].mask; i_post_count = tbl[r].post;
      tick();
      check($sformatf("tbl%0d_state", r), 64'(o_state), 64'(tbl[r].st));
      check($sformatf("tbl%0d_fill", r), 64'(o_fill), 64'(tbl[r].fill));
      check($sformatf("tbl%0d_hit0", r), 64'(o_watch_hits[15:0]), 64'(tbl[r].h0));
      check($sformatf("tbl%0d_hit1", r), 64'(o_watch_hits[31:16]), 64'(tbl[r].h1));
    end
    i_arm = 1'b0; i_retire = 1'b0; i_mem_DV = 1'b0; i_trig_watch_mask = '0;

    // ---- readback blocked while ARMED
    i_arm = 1'b1; tick(); i_arm = 1'b0;
    i_retire = 1'b1; i_PC = 32'hA000_0000; tick(); tick(); i_retire = 1'b0;
    check("armed_fill", 64'(o_fill), 64'd2);
    i_rd_en = 1'b1; i_rd_idx = 4'd0; tick(); i_rd_en = 1'b0;
    check("armed_rd_valid", 64'(o_rd_valid), 64'd0);

    // ---- reset during POST
    i_trig_pc = 32'hB000_0000; i_trig_pc_en = 1'b1; i_post_count = 16'd5;
    i_retire = 1'b1; i_PC = 32'hB000_0000; tick(); i_retire = 1'b0;
    check("post_state", 64'(o_state), 64'd2);
    i_reset_n = 1'b0; tick(); i_reset_n = 1'b1;
    check("rst2_state", 64'(o_state), 64'd0);
    check("rst2_fill", 64'(o_fill), 64'd0);
    check("rst2_icount", 64'(o_instr_count), 64'd0);
    check("rst2_hits", 64'(o_watch_hits), 64'd0);
    check("rst2_rd", {31'd0, o_rd_valid, o_rd_pc}, 64'd0);

    // ---- wrap-around: trigger on 40th retire, post_count 0
    i_trig_pc = 32'h0000_1000 + 32'd160; i_post_count = 16'd0;
    i_arm = 1'b1; tick(); i_arm = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      i_retire = 1'b1; i_PC = 32'h0000_1000 + 32'(4 * k); i_instruction = 32'(k);
      tick();
    end
    i_retire = 1'b0; i_trig_pc_en = 1'b0;
    check("wrap_state", 64'(o_state), 64'd3);
    check("wrap_fill", 64'(o_fill), 64'd16);
    check("wrap_icount", 64'(o_instr_count), 64'd40);
    i_rd_en = 1'b1; i_rd_idx = 4'd0; tick();
    check("wrap_rd0_pc", 64'(o_rd_pc), 64'h1064);
    check("wrap_rd0_instr", 64'(o_rd_instr), 64'd25);
    i_rd_idx = 4'd15; tick(); i_rd_en = 1'b0;
    check("wrap_rd15_pc", 64'(o_rd_pc), 64'h10A0);
    check("wrap_rd15_valid", 64'(o_rd_valid), 64'd1);

    // ---- stall detection
    i_retire = 1'b1; tick(); i_retire = 1'b0;
    check("stall_after_retire", 64'(o_stall), 64'd0);
    for (int k = 0; k < 7; k++) tick();
    check("stall_7idle", 64'(o_stall), 64'd0);
    tick();
    check("stall_8idle", 64'(o_stall), 64'(exp_stall_hi));
    tick();
    check("stall_hold", 64'(o_stall), 64'(exp_stall_hi));
    i_retire = 1'b1; tick(); i_retire = 1'b0;
    check("stall_clear", 64'(o_stall), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
